// File: rtl/mem_lsu_pkg.sv
// Shared opcode type and access-size helpers for the load/store unit.
package mem_lsu_pkg;

   localparam int MEM_DATA_DEPTH = 4096;

   typedef enum logic [2:0] {
      MEM_LB  = 3'd0,
      MEM_LH  = 3'd1,
      MEM_LW  = 3'd2,
      MEM_LBU = 3'd3,
      MEM_LHU = 3'd4,
      MEM_SB  = 3'd5,
      MEM_SH  = 3'd6,
      MEM_SW  = 3'd7
   } mem_op_e;

   function automatic logic [2:0] mem_size(input mem_op_e op);
      case (op)
         MEM_LB, MEM_LBU, MEM_SB: return 3'd1;
         MEM_LH, MEM_LHU, MEM_SH: return 3'd2;
         default:                 return 3'd4;
      endcase
   endfunction

   function automatic logic mem_is_store(input mem_op_e op);
      return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
   endfunction

   // Only the unsigned byte/half loads zero-extend; every other load sign-extends.
   function automatic logic mem_is_signed(input mem_op_e op);
      return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW);
   endfunction

endpackage

// File: rtl/mem_lsu_ram.sv
// Single-port data RAM with byte-enable writes and a registered read port.
module mem_lsu_ram
   import mem_lsu_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int DEPTH      = MEM_DATA_DEPTH,
   localparam int NB         = DATA_WIDTH / 8,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [NB-1:0]         be,
   input  logic [AW-1:0]         addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Read data holds its value whenever the port is idle or writing.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < NB; i++) begin
               if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit with private byte-enabled RAM; define MEM_MISALIGN_EN to execute
// misaligned accesses (splitting across two words) instead of rejecting them.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = MEM_DATA_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            req_op,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int OW = $clog2(NB);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

   state_e                state_q, state_d;
   mem_op_e               op_q, op_d;
   logic [OW-1:0]         off_q, off_d;
   logic [AW-1:0]         word_q, word_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] lo_q, lo_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;

   logic                  ram_en, ram_we;
   logic [NB-1:0]         ram_be;
   logic [AW-1:0]         ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

   logic [2:0]              size;
   logic                    is_store, split, reject, sign_bit;
   logic [4:0]              end_off;
   logic [2*NB-1:0]         lane_mask, st_be;
   logic [2*DATA_WIDTH-1:0] st_data;
   logic [DATA_WIDTH-1:0]   ld_hi, ld_lo, ld_raw, ld_val;
   logic [AW-1:0]           word_next;
   logic                    unused_addr_bits;

   assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:OW+AW];

   mem_lsu_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
   ) u_ram (
      .clk  (clk),
      .en   (ram_en),
      .we   (ram_we),
      .be   (ram_be),
      .addr (ram_addr),
      .wdata(ram_wdata),
      .rdata(ram_rdata)
   );

   // Datapath views of the registered request: lane placement for stores and a
   // two-word window for loads, so split and unsplit accesses share one shifter.
   always_comb begin
      size      = mem_size(op_q);
      is_store  = mem_is_store(op_q);
      end_off   = 5'(off_q) + 5'(size);
      split     = end_off > 5'(NB);
      word_next = word_q + AW'(1);
`ifdef MEM_MISALIGN_EN
      reject    = 1'b0;
`else
      reject    = (5'(off_q) & (5'(size) - 5'd1)) != 5'd0;
`endif
      lane_mask = '0;
      for (int i = 0; i < 4; i++) begin
         if (i < int'(size)) lane_mask[i] = 1'b1;
      end
      st_be   = lane_mask << off_q;
      st_data = {{DATA_WIDTH{1'b0}}, wdata_q} << {off_q, 3'b000};
      ld_hi   = (state_q == ACC1) ? ram_rdata : '0;
      ld_lo   = (state_q == ACC0) ? ram_rdata : lo_q;
      ld_raw  = DATA_WIDTH'({ld_hi, ld_lo} >> {off_q, 3'b000});
      case (size)
         3'd1:    sign_bit = ld_raw[7];
         3'd2:    sign_bit = ld_raw[15];
         default: sign_bit = ld_raw[31];
      endcase
      ld_val = ld_raw;
      for (int i = 8; i < DATA_WIDTH; i++) begin
         if (i >= 8 * int'(size)) ld_val[i] = mem_is_signed(op_q) & sign_bit;
      end
   end

   // The first RAM read goes out in the accept cycle; a split load reads the
   // next word from ACC0 so both halves meet in ACC1.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      off_d       = off_q;
      word_d      = word_q;
      wdata_d     = wdata_q;
      lo_d        = lo_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      ram_en      = 1'b0;
      ram_we      = 1'b0;
      ram_be      = '0;
      ram_addr    = word_q;
      ram_wdata   = st_data[DATA_WIDTH-1:0];
      unique case (state_q)
         IDLE: begin
            ram_addr = req_addr[OW +: AW];
            if (req_valid) begin
               ram_en      = 1'b1;
               op_d        = mem_op_e'(req_op);
               off_d       = req_addr[OW-1:0];
               word_d      = req_addr[OW +: AW];
               wdata_d     = req_wdata;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
               state_d     = ACC0;
            end
         end
         ACC0: begin
            lo_d = ram_rdata;
            if (reject) begin
               rsp_err_d = 1'b1;
               state_d   = RESP;
            end else if (split) begin
               ram_en  = 1'b1;
               state_d = ACC1;
               if (is_store) begin
                  ram_we = 1'b1;
                  ram_be = st_be[NB-1:0];
               end else begin
                  ram_addr = word_next;
               end
            end else begin
               if (is_store) begin
                  ram_en = 1'b1;
                  ram_we = 1'b1;
                  ram_be = st_be[NB-1:0];
               end else begin
                  rsp_rdata_d = ld_val;
               end
               state_d = RESP;
            end
         end
         ACC1: begin
            if (is_store) begin
               ram_en    = 1'b1;
               ram_we    = 1'b1;
               ram_addr  = word_next;
               ram_be    = st_be[2*NB-1:NB];
               ram_wdata = st_data[2*DATA_WIDTH-1:DATA_WIDTH];
            end else begin
               rsp_rdata_d = ld_val;
            end
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= MEM_LB;
         off_q       <= '0;
         word_q      <= '0;
         wdata_q     <= '0;
         lo_q        <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         off_q       <= off_d;
         word_q      <= word_d;
         wdata_q     <= wdata_d;
         lo_q        <= lo_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed and random accesses checked against a byte-array memory model.
module tb_mem_lsu;
   import mem_lsu_pkg::*;

   localparam int MEM_BYTES = 4096 * 4;
`ifdef MEM_MISALIGN_EN
   localparam bit MISALIGN_EN = 1'b1;
`else
   localparam bit MISALIGN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'd0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] last_rdata;
   logic [7:0]  model_mem [MEM_BYTES];

   mem_lsu #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .DEPTH     (4096)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_op   (req_op),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int op_bytes(input mem_op_e op);
      case (op)
         MEM_LB, MEM_LBU, MEM_SB: return 1;
         MEM_LH, MEM_LHU, MEM_SH: return 2;
         default:                 return 4;
      endcase
   endfunction

   // Memory is a flat byte array; an access touches bytes addr..addr+n-1 modulo its size.
   task automatic model_access(input mem_op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err, output int lat);
      int          n;
      int          off;
      bit          store;
      logic [31:0] v;
      int unsigned a;
      n     = op_bytes(op);
      off   = int'(addr[1:0]);
      store = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
      v     = '0;
      rdata = '0;
      err   = 1'b0;
      if ((off % n) != 0 && !MISALIGN_EN) begin
         err = 1'b1;
         lat = 2;
      end else begin
         lat = (off + n > 4) ? 3 : 2;
         for (int i = 0; i < n; i++) begin
            a = (addr + 32'(i)) & 32'(MEM_BYTES - 1);
            if (store) model_mem[a] = wdata[8*i +: 8];
            else v[8*i +: 8] = model_mem[a];
         end
         if (!store) begin
            if ((op == MEM_LB || op == MEM_LH) && v[8*n-1]) begin
               for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
            end
            rdata = v;
         end
      end
   endtask

   task automatic send_req(input mem_op_e op, input logic [31:0] addr, input logic [31:0] wdata);
      int w;
      w = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && w < 10) begin
         @(negedge clk);
         w++;
      end
      check_output("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op    = 3'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
   endtask

   task automatic apply_stimulus(input mem_op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int hold);
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          c;
      model_access(op, addr, wdata, exp_rdata, exp_err, exp_lat);
      send_req(op, addr, wdata);
      c = 1;
      while (rsp_valid !== 1'b1 && c < 8) begin
         @(posedge clk);
         #1;
         c++;
      end
      check_output($sformatf("%s@%h latency", op.name(), addr), 32'(c), 32'(exp_lat));
      check_output($sformatf("%s@%h rdata", op.name(), addr), rsp_rdata, exp_rdata);
      check_output($sformatf("%s@%h err", op.name(), addr), 32'(rsp_err), 32'(exp_err));
      last_rdata = rsp_rdata;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         #1;
         check_output("hold_valid", 32'(rsp_valid), 32'd1);
         check_output("hold_rdata", rsp_rdata, exp_rdata);
         check_output("hold_err", 32'(rsp_err), 32'(exp_err));
         check_output("hold_req_ready", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check_output("taken_req_ready", 32'(req_ready), 32'd1);
      check_output("taken_rsp_valid", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      // Reset held for three cycles, with a store presented that must not land.
      rst       = 1'b1;
      req_valid = 1'b1;
      req_op    = MEM_SW;
      req_addr  = 32'h80;
      req_wdata = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_req_ready", 32'(req_ready), 32'd1);
      check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      rst       = 1'b0;
      #1;
      check_output("post_reset_req_ready", 32'(req_ready), 32'd1);
      check_output("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("post_reset_rdata", rsp_rdata, 32'd0);
      check_output("post_reset_err", 32'(rsp_err), 32'd0);

      // Word store followed by loads of every width and extension.
      apply_stimulus(MEM_SW, 32'h80, 32'hDEAD_BEEF, 0);
      apply_stimulus(MEM_LW, 32'h80, 32'h0, 0);
      check_output("lw80_const", last_rdata, 32'hDEAD_BEEF);
      apply_stimulus(MEM_LB, 32'h83, 32'h0, 0);
      check_output("lb83_const", last_rdata, 32'hFFFF_FFDE);
      apply_stimulus(MEM_LBU, 32'h83, 32'h0, 0);
      check_output("lbu83_const", last_rdata, 32'h0000_00DE);
      apply_stimulus(MEM_LH, 32'h82, 32'h0, 0);
      check_output("lh82_const", last_rdata, 32'hFFFF_DEAD);
      apply_stimulus(MEM_LHU, 32'h80, 32'h0, 0);
      check_output("lhu80_const", last_rdata, 32'h0000_BEEF);

      // Misaligned halfword store, then mixed byte/half lanes.
      apply_stimulus(MEM_SH, 32'h81, 32'h0000_1234, 0);
      apply_stimulus(MEM_LW, 32'h80, 32'h0, 0);
      check_output("lw80_after_sh81", last_rdata, MISALIGN_EN ? 32'hDE12_34EF : 32'hDEAD_BEEF);
      apply_stimulus(MEM_SB, 32'h81, 32'h0000_0055, 0);
      apply_stimulus(MEM_SH, 32'h82, 32'h0000_6677, 0);
      apply_stimulus(MEM_LW, 32'h80, 32'h0, 0);
      apply_stimulus(MEM_LB, 32'h81, 32'h0, 0);

      // Store straddling the last word wraps into word 0.
      apply_stimulus(MEM_SW, 32'h3FFC, 32'h1122_3344, 0);
      apply_stimulus(MEM_SW, 32'h0, 32'h5566_7788, 0);
      apply_stimulus(MEM_SW, 32'h3FFE, 32'hAABB_CCDD, 0);
      apply_stimulus(MEM_LW, 32'h3FFE, 32'h0, 0);
      apply_stimulus(MEM_LW, 32'h3FFC, 32'h0, 0);
      apply_stimulus(MEM_LW, 32'h0, 32'h0, 0);
      check_output("lw0_after_wrap", last_rdata, MISALIGN_EN ? 32'h5566_AABB : 32'h5566_7788);

      // Consumer stalls for five cycles in RESP.
      apply_stimulus(MEM_LW, 32'h80, 32'h0, 5);

      // Reset during ACC0 of a store aborts it; stores presented during reset are ignored.
      apply_stimulus(MEM_SW, 32'h84, 32'h0102_0304, 0);
      send_req(MEM_SW, 32'h84, 32'h0BAD_F00D);
      #2;
      rst = 1'b1;
      #1;
      check_output("abort_acc0_req_ready", 32'(req_ready), 32'd1);
      check_output("abort_acc0_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = MEM_SW;
      req_addr  = 32'h84;
      req_wdata = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst       = 1'b0;
      apply_stimulus(MEM_LW, 32'h84, 32'h0, 0);
      check_output("lw84_after_abort", last_rdata, 32'h0102_0304);

`ifdef MEM_MISALIGN_EN
      // Reset while a split load sits in ACC1.
      send_req(MEM_LW, 32'h3FFE, 32'h0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_output("abort_acc1_req_ready", 32'(req_ready), 32'd1);
      check_output("abort_acc1_rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("abort_acc1_rdata", rsp_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
`endif

      // Random traffic over a small initialised window.
      for (int i = 0; i <= 16; i++) begin
         apply_stimulus(MEM_SW, 32'h100 + 32'(4 * i), $urandom, 0);
      end
      for (int i = 0; i < 120; i++) begin
         apply_stimulus(mem_op_e'(3'($urandom_range(0, 7))), 32'h100 + 32'($urandom_range(0, 63)),
                        $urandom, int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
